// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples the active-low 7-segment scan bus, decodes each settled
// digit dwell back to a 4-bit code and publishes complete 4-digit frames.
// Latency: capture 2+SETTLE_CYCLES cycles after inputs settle; frame published 1 cycle later.
// No backpressure: passive monitor. Optional macro SEG_HEX_DECODE_EN adds A-F decoding.
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int CNT_W          = 21
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  cathode,
  input  logic [3:0]  anode,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic [3:0]  seg_err,
  output logic        frame_valid,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_FULL  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_FULL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  state_t             state, state_nxt;
  logic [3:0]         an_m, s_an, an_q;
  logic [6:0]         cat_m, s_cat, cat_q;
  logic [CNT_W-1:0]   stable_cnt, stable_nxt;
  logic [CNT_W-1:0]   timeout_cnt;
  logic               dwell_ok, changed, capture, publish, timeout_hit;
  logic [3:0]         slot_oh;
  logic [3:0][3:0]    stg_code;
  logic [3:0]         stg_blank, stg_err, mask;
  logic [3:0]         dec_code;
  logic               dec_blank, dec_err;

  // Two-flop synchronizer plus a one-cycle history used to detect bus changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_m  <= 4'hF;
      s_an  <= 4'hF;
      an_q  <= 4'hF;
      cat_m <= 7'h7F;
      s_cat <= 7'h7F;
      cat_q <= 7'h7F;
    end else begin
      an_m  <= anode;
      s_an  <= an_m;
      an_q  <= s_an;
      cat_m <= cathode;
      s_cat <= cat_m;
      cat_q <= s_cat;
    end
  end

  // A dwell is valid only when exactly one digit enable is active.
  always_comb begin
    slot_oh = ~s_an;
    dwell_ok = 1'b0;
    case (slot_oh)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: dwell_ok = 1'b1;
      default:                            dwell_ok = 1'b0;
    endcase
    changed = (s_an != an_q) || (s_cat != cat_q);
  end

  // Pattern decode (gfedcba, active high); blank is a valid "digit off" pattern.
  always_comb begin
    dec_code  = 4'hF;
    dec_err   = 1'b0;
    dec_blank = 1'b0;
    case (~s_cat)
      7'h3F: dec_code = 4'h0;
      7'h06: dec_code = 4'h1;
      7'h5B: dec_code = 4'h2;
      7'h4F: dec_code = 4'h3;
      7'h66: dec_code = 4'h4;
      7'h6D: dec_code = 4'h5;
      7'h7D: dec_code = 4'h6;
      7'h07: dec_code = 4'h7;
      7'h7F: dec_code = 4'h8;
      7'h6F: dec_code = 4'h9;
`ifdef SEG_HEX_DECODE_EN
      7'h77: dec_code = 4'hA;
      7'h7C: dec_code = 4'hB;
      7'h39: dec_code = 4'hC;
      7'h5E: dec_code = 4'hD;
      7'h79: dec_code = 4'hE;
      7'h71: dec_code = 4'hF;
`endif
      7'h00: begin
        dec_code  = 4'h0;
        dec_blank = 1'b1;
      end
      default: begin
        dec_code = 4'hF;
        dec_err  = 1'b1;
      end
    endcase
  end

  // Dwell FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      stable_cnt <= '0;
    end else begin
      state      <= state_nxt;
      stable_cnt <= stable_nxt;
    end
  end

  // Dwell FSM: settle counting, one capture per stable dwell.
  always_comb begin
    state_nxt  = state;
    stable_nxt = stable_cnt;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (dwell_ok) begin
          state_nxt  = SETTLE;
          stable_nxt = CNT_ONE;
        end
      end
      SETTLE: begin
        if (!dwell_ok) begin
          state_nxt  = IDLE;
          stable_nxt = '0;
        end else if (changed) begin
          stable_nxt = CNT_ONE;
        end else if (stable_cnt >= SETTLE_LAST) begin
          capture    = 1'b1;
          stable_nxt = SETTLE_FULL;
          state_nxt  = HELD;
        end else begin
          stable_nxt = stable_cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!dwell_ok) begin
          state_nxt  = IDLE;
          stable_nxt = '0;
        end else if (changed) begin
          state_nxt  = SETTLE;
          stable_nxt = CNT_ONE;
        end
      end
      default: begin
        state_nxt  = IDLE;
        stable_nxt = '0;
      end
    endcase
  end

  // Mask full is registered, so publication happens the cycle after the last capture.
  always_comb begin
    publish     = (mask == 4'hF);
    timeout_hit = !capture && (timeout_cnt >= TIMEOUT_LAST);
  end

  // Staging, frame publication and capture timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_code    <= '0;
      stg_blank   <= '0;
      stg_err     <= '0;
      mask        <= '0;
      timeout_cnt <= '0;
      digits      <= '0;
      blank       <= '0;
      seg_err     <= '0;
      frame_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= publish;

      if (capture) begin
        for (int i = 0; i < 4; i++) begin
          if (slot_oh[i]) begin
            stg_code[i]  <= dec_code;
            stg_blank[i] <= dec_blank;
            stg_err[i]   <= dec_err;
          end
        end
      end

      // A capture in the same cycle as a clear still lands in the fresh mask.
      mask <= ((publish || timeout_hit) ? 4'h0 : mask) | (capture ? slot_oh : 4'h0);

      if (capture) begin
        timeout_cnt <= '0;
      end else if (timeout_cnt < TIMEOUT_FULL) begin
        timeout_cnt <= timeout_cnt + CNT_ONE;
      end

      if (publish) begin
        digits      <= stg_code;
        blank       <= stg_blank;
        seg_err     <= stg_err;
        frame_valid <= 1'b1;
      end else if (timeout_hit) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: scans frames on the bus, predicts each published frame
// into a scoreboard queue, and checks frame timing, timeout and reset behaviour.
module tb_seg_scan_decoder;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 100;
  // Cycles from driving a new dwell to the frame_done pulse of a completing capture.
  localparam int DONE_LAT = 2 + SETTLE + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  cathode;
  logic [3:0]  anode;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic [3:0]  seg_err;
  logic        frame_valid;
  logic        frame_done;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  b;
    logic [3:0]  e;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  seg_scan_decoder #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W         (21)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cathode    (cathode),
    .anode      (anode),
    .digits     (digits),
    .blank      (blank),
    .seg_err    (seg_err),
    .frame_valid(frame_valid),
    .frame_done (frame_done)
  );

  // Scoreboard: every published frame must match the oldest predicted frame.
  always @(negedge clk) begin
    if (!rst && frame_done) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL frame_unexpected: got digits=%h blank=%b seg_err=%b, required no frame", digits, blank, seg_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({digits, blank, seg_err, frame_valid} !== {e.d, e.b, e.e, 1'b1}) begin
          n_bad++;
          $display("FAIL frame_content: got d=%h b=%b e=%b v=%b, required d=%h b=%b e=%b v=1",
                   digits, blank, seg_err, frame_valid, e.d, e.b, e.e);
        end
      end
    end
  end

  // Drives one dwell of 'cycles' cycles; optional one-cycle cathode glitch after cycle glitch_at.
  // Reports the first cycle (counted from the drive) where frame_done was seen, or -1.
  task automatic dwell(input int slot, input logic [6:0] pat, input int cycles,
                       input int glitch_at, output int done_at);
    logic [3:0] an_v;
    an_v = 4'b0001 << slot;
    @(posedge clk); #1;
    anode   = ~an_v;
    cathode = ~pat;
    done_at = -1;
    for (int k = 1; k <= cycles; k++) begin
      @(posedge clk); #1;
      if (done_at < 0 && frame_done) done_at = k;
      if (glitch_at > 0 && k == glitch_at)     cathode = ~(pat ^ 7'h08);
      if (glitch_at > 0 && k == glitch_at + 1) cathode = ~pat;
    end
  endtask

  task automatic go_idle(input int cycles);
    @(posedge clk); #1;
    anode   = 4'hF;
    cathode = 7'h7F;
    repeat (cycles) @(posedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    anode = 4'hF;
    cathode = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({digits, blank, seg_err, frame_valid, frame_done} !== 26'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got d=%h b=%b e=%b v=%b done=%b, required all zero",
               digits, blank, seg_err, frame_valid, frame_done);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic;
    int d0, d1, d2, d3;
    sb.push_back('{d: 16'h3210, b: 4'b0000, e: 4'b0000});
    dwell(0, 7'h3F, 40, 0, d0);
    dwell(1, 7'h06, 40, 0, d1);
    dwell(2, 7'h5B, 40, 0, d2);
    dwell(3, 7'h4F, 40, 0, d3);
    n_cmp++;
    if ({d0, d1, d2} !== {-32'sd1, -32'sd1, -32'sd1}) begin
      n_bad++;
      $display("FAIL basic_early_done: got %0d/%0d/%0d, required -1/-1/-1", d0, d1, d2);
    end
    n_cmp++;
    if (d3 !== DONE_LAT) begin
      n_bad++;
      $display("FAIL basic_latency: got %0d, required %0d", d3, DONE_LAT);
    end
  endtask

  task automatic test_short_dwell;
    int d0, d1, d2, d3, e0, e1, e2;
    sb.push_back('{d: 16'h4765, b: 4'b0000, e: 4'b0000});
    dwell(0, 7'h06, 40, 0, d0);
    dwell(1, 7'h5B, 40, 0, d1);
    dwell(2, 7'h4F, 10, 0, d2);
    dwell(3, 7'h66, 40, 0, d3);
    dwell(0, 7'h6D, 40, 0, e0);
    dwell(1, 7'h7D, 40, 0, e1);
    dwell(2, 7'h07, 40, 0, e2);
    n_cmp++;
    if ({d0, d1, d2, d3, e0, e1} !== {6{-32'sd1}}) begin
      n_bad++;
      $display("FAIL short_early_done: got %0d %0d %0d %0d %0d %0d, required all -1",
               d0, d1, d2, d3, e0, e1);
    end
    n_cmp++;
    if (e2 !== DONE_LAT) begin
      n_bad++;
      $display("FAIL short_completion: got %0d, required %0d", e2, DONE_LAT);
    end
  endtask

  task automatic test_glitch;
    int d0, d1, d2, d3;
    sb.push_back('{d: 16'h7654, b: 4'b0000, e: 4'b0000});
    dwell(0, 7'h66, 40, 0, d0);
    dwell(1, 7'h6D, 40, 0, d1);
    dwell(2, 7'h7D, 40, 0, d2);
    dwell(3, 7'h07, 40, 8, d3);
    n_cmp++;
    if ({d0, d1, d2} !== {-32'sd1, -32'sd1, -32'sd1}) begin
      n_bad++;
      $display("FAIL glitch_early_done: got %0d/%0d/%0d, required -1/-1/-1", d0, d1, d2);
    end
    n_cmp++;
    if (d3 !== 9 + DONE_LAT) begin
      n_bad++;
      $display("FAIL glitch_restart: got %0d, required %0d", d3, 9 + DONE_LAT);
    end
  endtask

  task automatic test_blank_hex;
    int d0, d1, d2, d3;
`ifdef SEG_HEX_DECODE_EN
    sb.push_back('{d: 16'hA100, b: 4'b0010, e: 4'b0000});
`else
    sb.push_back('{d: 16'hF100, b: 4'b0010, e: 4'b1000});
`endif
    dwell(0, 7'h3F, 40, 0, d0);
    dwell(1, 7'h00, 40, 0, d1);
    dwell(2, 7'h06, 40, 0, d2);
    dwell(3, 7'h77, 40, 0, d3);
    n_cmp++;
    if (d3 !== DONE_LAT) begin
      n_bad++;
      $display("FAIL blank_hex_done: got %0d, required %0d", d3, DONE_LAT);
    end
  endtask

  task automatic test_timeout;
    int d0, d1, d2, d3, fall_at, extra_done;
    logic digits_moved;
    sb.push_back('{d: 16'h6789, b: 4'b0000, e: 4'b0000});
    dwell(0, 7'h6F, 40, 0, d0);
    dwell(1, 7'h7F, 40, 0, d1);
    dwell(2, 7'h07, 40, 0, d2);
    dwell(3, 7'h7D, 40, 0, d3);
    // Idle bus from here; cycle numbering continues from the slot-3 dwell start.
    anode   = 4'hF;
    cathode = 7'h7F;
    fall_at = -1;
    extra_done = 0;
    digits_moved = 1'b0;
    for (int k = 41; k <= 160; k++) begin
      @(posedge clk); #1;
      if (fall_at < 0 && !frame_valid) fall_at = k;
      if (frame_done) extra_done++;
      if (digits !== 16'h6789) digits_moved = 1'b1;
    end
    n_cmp++;
    if (d3 !== DONE_LAT) begin
      n_bad++;
      $display("FAIL timeout_frame_done: got %0d, required %0d", d3, DONE_LAT);
    end
    n_cmp++;
    if (fall_at !== DONE_LAT - 1 + TIMEOUT) begin
      n_bad++;
      $display("FAIL timeout_fall_cycle: got %0d, required %0d", fall_at, DONE_LAT - 1 + TIMEOUT);
    end
    n_cmp++;
    if (extra_done !== 0 || digits_moved !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_hold: got pulses=%0d moved=%b, required 0/0", extra_done, digits_moved);
    end
  endtask

  task automatic test_mid_reset;
    int d0, d1, d2, d3;
    dwell(0, 7'h06, 40, 0, d0);
    dwell(1, 7'h06, 40, 0, d1);
    @(posedge clk); #1;
    rst = 1'b1;
    anode = 4'hF;
    cathode = 7'h7F;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({digits, blank, seg_err, frame_valid} !== 25'h0) begin
      n_bad++;
      $display("FAIL midreset_clear: got d=%h v=%b, required 0/0", digits, frame_valid);
    end
    rst = 1'b0;
    sb.push_back('{d: 16'h8642, b: 4'b0000, e: 4'b0000});
    dwell(0, 7'h5B, 40, 0, d0);
    dwell(1, 7'h66, 40, 0, d1);
    dwell(2, 7'h7D, 40, 0, d2);
    n_cmp++;
    if ({d0, d1, d2} !== {-32'sd1, -32'sd1, -32'sd1} || digits !== 16'h0 || frame_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_partial: got %0d/%0d/%0d d=%h v=%b, required -1/-1/-1 d=0000 v=0",
               d0, d1, d2, digits, frame_valid);
    end
    dwell(3, 7'h7F, 40, 0, d3);
    n_cmp++;
    if (d3 !== DONE_LAT) begin
      n_bad++;
      $display("FAIL midreset_done: got %0d, required %0d", d3, DONE_LAT);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    go_idle(5);
    test_short_dwell();
    go_idle(5);
    test_glitch();
    go_idle(5);
    test_blank_hex();
    go_idle(5);
    test_timeout();
    test_mid_reset();
    go_idle(5);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL frames_outstanding: got %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
Receiving end of the multiplexed 7-segment bus. It samples the active-low cathode/anode lines and waits for each digit dwell to settle. It then decodes segment patterns back into 4-bit digit codes and assembles complete 4-digit frames. It is used as an on-board self-check and bench monitor for the display path, in the same clk domain as the game logic.

Parameters:
SETTLE_CYCLES, 16, consecutive stable cycles required before a dwell is captured (>=2)
TIMEOUT_CYCLES, 2000000, cycles without any capture before frame_valid drops
CNT_W, 21, width of the settle and timeout counters (must hold TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cathode  in  7  segment lines, active low; bit0=a ... bit6=g
anode  in  4  digit enables, active low; anode[0]=rightmost digit (slot 0)
digits  out  16  last complete frame; slot n at [4n+3:4n]
blank  out  4  per slot: captured pattern was all segments off
seg_err  out  4  per slot: pattern was not decodable
frame_valid  out  1  a frame was completed and no timeout has occurred since
frame_done  out  1  one-cycle pulse when digits/blank/seg_err update

Behaviour:
- Reset: all outputs 0, staging cleared, sync flops 1 (idle bus), counters 0, state IDLE.
- Inputs pass through a 2-flop synchronizer. All logic below uses the synchronized values (s_an, s_cat).
- Valid dwell: s_an has exactly one bit low. All-high or multiple-low means no dwell.
- FSM:
  - IDLE: no valid dwell. Go to SETTLE when a valid dwell appears; stable_cnt=1.
  - SETTLE: if s_an or s_cat differs from the previous cycle, or the dwell becomes invalid, restart (stable_cnt=1, or IDLE if invalid). Otherwise stable_cnt++. When stable_cnt reaches SETTLE_CYCLES, capture into the staging slot and go to HELD.
  - HELD: no further capture while s_an and s_cat stay unchanged. Any change goes to SETTLE (or IDLE if invalid), so one capture per dwell.
- Latency: a capture occurs 2 + SETTLE_CYCLES cycles after the raw inputs become stable.
- Decode: p = ~s_cat, as gfedcba.
  - Digits: 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9.
  - p=00: code 0, blank=1, seg_err=0.
  - Any other pattern: code F, seg_err=1.
- Frame assembly: a 4-bit capture mask sets the bit for the captured slot.
  - Recapturing a slot before the frame completes overwrites that staging entry.
  - When the mask becomes 1111, on the following cycle: staging is copied to digits/blank/seg_err, frame_done=1 for one cycle, frame_valid=1, and the mask is cleared.
- Timeout: timeout_cnt resets on every capture and increments otherwise, saturating.
  - On reaching TIMEOUT_CYCLES: frame_valid=0 and the mask is cleared.
  - digits, blank and seg_err hold their last values.
- Simultaneous frame completion and timeout cannot occur, because a capture resets the timer. Completion wins by construction.
- rst mid-dwell or mid-frame returns everything to reset values on the next clk edge. No partial frame is published.

Optional Feature:
SEG_HEX_DECODE_EN
- Defined: also decode 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F with seg_err=0.
- Undefined: these patterns give code F with seg_err=1.

Test Plan:
- Reset, then scan ~{3F,06,5B,4F} on slots 0..3, each dwell 40 cycles with SETTLE_CYCLES=16 -> one frame_done pulse; digits=16h3210, seg_err=0, blank=0, frame_valid=1.
- Dwell on slot 2 lasting only 10 cycles, then the full scan resumes -> slot 2 is not captured until a >=18-cycle dwell occurs; frame_done fires only after all 4 slots are captured.
- Cathode glitch at cycle 8 of a 40-cycle dwell -> settle restarts; capture happens 16 cycles after the glitch; exactly one capture per dwell.
- Slot 1 pattern 00, slot 3 pattern 77 -> blank=0010. With the macro off: seg_err=1000 and digits[15:12]=F. With the macro on: seg_err=0000 and digits[15:12]=A.
- anode=1111 held for TIMEOUT_CYCLES (set to 100) after a valid frame -> frame_valid falls at cycle 100; digits unchanged; no frame_done pulse.
- rst asserted after 2 of 4 slots are captured, then a full scan -> the first frame_done occurs only after 4 new captures; outputs stay 0 until then.
